// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between core writeback and an aux unit.
// Define REGFILE_ARB_STARVE_GUARD_EN to force an aux grant after STARVE_LIMIT lost cycles; otherwise core has strict priority.
module regfile_write_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              coreValid,
   output logic              coreReady,
   input  logic [ADDR_W-1:0] coreRd,
   input  logic [DATA_W-1:0] coreData,
   input  logic              auxValid,
   output logic              auxReady,
   input  logic [ADDR_W-1:0] auxRd,
   input  logic [DATA_W-1:0] auxData,
   output logic              regWrite,
   output logic [ADDR_W-1:0] rdAddr,
   output logic [DATA_W-1:0] writeData,
   output logic              auxStarved
);
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..15");
   end
   logic              forced;
   logic              core_xfer;
   logic              aux_xfer;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;
`ifdef REGFILE_ARB_STARVE_GUARD_EN
   logic [3:0] waitCnt;
   assign forced = auxValid && (waitCnt == 4'(STARVE_LIMIT));
   // Counts consecutive cycles aux was presented but lost, saturating at the limit.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) waitCnt <= '0;
      else if (aux_xfer) waitCnt <= '0;
      else if (auxValid && waitCnt != 4'(STARVE_LIMIT)) waitCnt <= waitCnt + 4'd1;
   end
`else
   assign forced = 1'b0;
`endif
   assign coreReady  = !forced;
   assign auxReady   = forced || (auxValid && !coreValid);
   assign auxStarved = forced;
   assign core_xfer  = coreValid && coreReady;
   assign aux_xfer   = auxValid && auxReady;
   assign sel_rd     = aux_xfer ? auxRd : coreRd;
   assign sel_data   = aux_xfer ? auxData : coreData;
   // Writes to x0 are consumed but never enable the register file.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         regWrite  <= 1'b0;
         rdAddr    <= '0;
         writeData <= '0;
      end else begin
         regWrite <= (core_xfer || aux_xfer) && (sel_rd != '0);
         if (core_xfer || aux_xfer) begin
            rdAddr    <= sel_rd;
            writeData <= sel_data;
         end
      end
   end
endmodule
